// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the SDRAM client arbiter: FSM state encoding,
// the per-client command record and the default controller latencies.
package sdram_arb_pkg;

    localparam int ADDR_W     = 24;
    localparam int DATA_W     = 16;
    localparam int DEF_RD_LAT = 6;
    localparam int DEF_WR_LAT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic              we;
        logic              word;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
    } cl_cmd_t;

endpackage

// File: rtl/sdram_client_arb_rr_pick.sv
// Combinational round-robin picker: the first requester after last_grant wins.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [IW-1:0] grant,
    output logic          valid
);

    // Scan from the farthest candidate to the nearest so the nearest hit is the final write.
    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        valid = 1'b0;
        for (int i = N; i >= 1; i--) begin
            idx = (int'(last_grant) + i) % N;
            if (req[idx]) begin
                grant = IW'(idx);
                valid = 1'b1;
            end else begin
                grant = grant;
            end
        end
    end

endmodule

// File: rtl/sdram_client_arb.sv
// Round-robin arbiter multiplexing several byte/word clients onto one SDRAM
// controller command port with fixed read/write completion latencies.
module sdram_client_arb
    import sdram_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int RD_LAT      = DEF_RD_LAT,
    parameter int WR_LAT      = DEF_WR_LAT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CLIENTS-1:0]      cl_req,
    input  logic [NUM_CLIENTS-1:0]      cl_we,
    input  logic [NUM_CLIENTS-1:0]      cl_word,
    input  logic [NUM_CLIENTS*24-1:0]   cl_addr,
    input  logic [NUM_CLIENTS*16-1:0]   cl_din,
    output logic [NUM_CLIENTS-1:0]      cl_ack,
    output logic [15:0]                 cl_dout,
    output logic [23:0]                 mem_addr,
    output logic [15:0]                 mem_din,
    output logic                        mem_word,
    output logic                        mem_rd,
    output logic                        mem_wr,
    input  logic [15:0]                 mem_dout
);

    localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam logic [7:0] RD_LOAD = 8'(RD_LAT - 2);
    localparam logic [7:0] WR_LOAD = 8'(WR_LAT - 2);

    state_e                 state_r;
    logic [IW-1:0]          grant_r;
    logic [IW-1:0]          last_grant_r;
    logic                   we_r;
    logic [7:0]             cnt_r;
    logic [NUM_CLIENTS-1:0] ack_prev_r;

    logic [NUM_CLIENTS-1:0] elig_s;
    logic [NUM_CLIENTS-1:0] pick_req_s;
    logic [NUM_CLIENTS-1:0] ack_hot_s;
    logic [IW-1:0]          pick_s;
    logic                   pick_valid_s;
    cl_cmd_t                cand_s;
    logic [23:0]            addr_a_s [NUM_CLIENTS];
    logic [15:0]            din_a_s  [NUM_CLIENTS];

    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_unpack
        assign addr_a_s[i] = cl_addr[i*24 +: 24];
        assign din_a_s[i]  = cl_din[i*16 +: 16];
    end

    // The client acked last cycle may still show a stale request; it yields unless it is alone.
    always_comb begin
        elig_s = cl_req & ~ack_prev_r;
        if (|elig_s) begin
            pick_req_s = elig_s;
        end else begin
            pick_req_s = cl_req;
        end
    end

    rr_pick #(.N(NUM_CLIENTS), .IW(IW)) u_pick (
        .req        (pick_req_s),
        .last_grant (last_grant_r),
        .grant      (pick_s),
        .valid      (pick_valid_s)
    );

    // Command fields of the candidate client and the one-hot ack vector of the granted client.
    always_comb begin
        cand_s.we   = cl_we[pick_s];
        cand_s.word = cl_word[pick_s];
        cand_s.addr = addr_a_s[pick_s];
        cand_s.din  = din_a_s[pick_s];
        ack_hot_s   = '0;
        ack_hot_s[grant_r] = 1'b1;
    end

    // Transaction FSM; every port output is a register written here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            grant_r      <= '0;
            last_grant_r <= IW'(NUM_CLIENTS - 1);
            we_r         <= 1'b0;
            cnt_r        <= 8'd0;
            ack_prev_r   <= '0;
            cl_ack       <= '0;
            cl_dout      <= 16'd0;
            mem_addr     <= 24'd0;
            mem_din      <= 16'd0;
            mem_word     <= 1'b0;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
        end else begin
            cl_ack     <= '0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            ack_prev_r <= cl_ack;
            case (state_r)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        grant_r  <= pick_s;
                        we_r     <= cand_s.we;
                        mem_addr <= cand_s.addr;
                        mem_din  <= cand_s.din;
                        mem_word <= cand_s.word;
                        mem_rd   <= ~cand_s.we;
                        mem_wr   <= cand_s.we;
                        state_r  <= ST_ISSUE;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    cnt_r   <= we_r ? WR_LOAD : RD_LOAD;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt_r == 8'd0) begin
                        cl_ack  <= ack_hot_s;
                        cl_dout <= we_r ? cl_dout : mem_dout;
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r   <= cnt_r - 8'd1;
                    end
                end
                ST_DONE: begin
                    last_grant_r <= grant_r;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_client_arb.sv
// Directed bench for sdram_client_arb: expected strobes and acks are queued when
// requests are driven and matched cycle-exactly against the DUT outputs.
module tb_sdram_client_arb;

    typedef struct {
        int          cyc;
        logic        rd;
        logic        wr;
        logic [23:0] addr;
        logic [15:0] din;
        logic        word;
    } strobe_t;

    typedef struct {
        int          cyc;
        logic [3:0]  ack;
        logic        is_wr;
        logic [15:0] dout;
    } ack_t;

    logic        clk;
    logic        reset;
    logic [3:0]  cl_req;
    logic [3:0]  cl_we;
    logic [3:0]  cl_word;
    logic [95:0] cl_addr;
    logic [63:0] cl_din;
    logic [3:0]  cl_ack;
    logic [15:0] cl_dout;
    logic [23:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_word;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_dout;

    strobe_t     sq[$];
    ack_t        aq[$];
    int          cyc;
    int          n_cmp;
    int          n_bad;
    logic [15:0] exp_dout;

    sdram_client_arb #(.NUM_CLIENTS(4), .RD_LAT(6), .WR_LAT(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .cl_req   (cl_req),
        .cl_we    (cl_we),
        .cl_word  (cl_word),
        .cl_addr  (cl_addr),
        .cl_din   (cl_din),
        .cl_ack   (cl_ack),
        .cl_dout  (cl_dout),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_word (mem_word),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .mem_dout (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic set_cl(input int c, input logic r, input logic we, input logic wd,
                          input logic [23:0] a, input logic [15:0] d);
        cl_req[c]          = r;
        cl_we[c]           = we;
        cl_word[c]         = wd;
        cl_addr[c*24 +: 24] = a;
        cl_din[c*16 +: 16]  = d;
    endtask

    // Strobe in cycle p; ack RD_LAT / WR_LAT cycles later.
    task automatic xact(input int p, input logic we, input logic wd, input logic [23:0] a,
                        input logic [15:0] d, input int client, input logic [15:0] rdata);
        strobe_t s;
        ack_t    k;
        s.cyc = p; s.rd = ~we; s.wr = we; s.addr = a; s.din = d; s.word = wd;
        sq.push_back(s);
        k.cyc = p + (we ? 8 : 6); k.ack = 4'(1 << client); k.is_wr = we; k.dout = rdata;
        aq.push_back(k);
    endtask

    task automatic push_strobe_only(input int p, input logic we, input logic wd,
                                    input logic [23:0] a, input logic [15:0] d);
        strobe_t s;
        s.cyc = p; s.rd = ~we; s.wr = we; s.addr = a; s.din = d; s.word = wd;
        sq.push_back(s);
    endtask

    task automatic step();
        strobe_t s;
        ack_t    k;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (sq.size() > 0 && sq[0].cyc == cyc) begin
            s = sq.pop_front();
            chk("strobe", 96'({mem_rd, mem_wr, mem_addr, mem_din, mem_word}),
                96'({s.rd, s.wr, s.addr, s.din, s.word}));
        end else if (mem_rd || mem_wr) begin
            chk("strobe_unexpected", 96'({mem_rd, mem_wr}), 96'd0);
        end else begin
        end
        if (aq.size() > 0 && aq[0].cyc == cyc) begin
            k = aq.pop_front();
            if (!k.is_wr) exp_dout = k.dout;
            chk("ack", 96'({cl_ack, cl_dout}), 96'({k.ack, exp_dout}));
        end else begin
            if (cl_ack !== 4'd0) chk("ack_unexpected", 96'(cl_ack), 96'd0);
            chk("dout_hold", 96'(cl_dout), 96'(exp_dout));
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int c;
        cyc = 0; n_cmp = 0; n_bad = 0; exp_dout = 16'd0;
        reset = 1'b1; cl_req = 4'd0; cl_we = 4'd0; cl_word = 4'd0;
        cl_addr = 96'd0; cl_din = 64'd0; mem_dout = 16'hBEEF;

        run(2);
        chk("reset_outputs", 96'({cl_ack, mem_rd, mem_wr, mem_addr, mem_din, mem_word, cl_dout}), 96'd0);
        reset = 1'b0;
        run(1);

        // Single read by client 1.
        c = cyc;
        set_cl(1, 1'b1, 1'b0, 1'b1, 24'h012345, 16'h0000);
        xact(c + 1, 1'b0, 1'b1, 24'h012345, 16'h0000, 1, 16'hBEEF);
        run(1);
        set_cl(1, 1'b0, 1'b0, 1'b1, 24'h012345, 16'h0000);
        run(8);

        // Byte write by client 2; cl_dout must keep the previous read value.
        c = cyc;
        set_cl(2, 1'b1, 1'b1, 1'b0, 24'h000101, 16'h00A5);
        xact(c + 1, 1'b1, 1'b0, 24'h000101, 16'h00A5, 2, 16'h0000);
        run(1);
        set_cl(2, 1'b0, 1'b1, 1'b0, 24'h000101, 16'h00A5);
        run(10);

        // Reset, then all four clients request together and hold: 0,1,2,3,0.
        reset = 1'b1; exp_dout = 16'd0;
        run(1);
        reset = 1'b0;
        mem_dout = 16'h1234;
        c = cyc;
        for (int k = 0; k < 4; k++) set_cl(k, 1'b1, 1'b0, 1'b1, 24'h001000 + 24'(k), 16'(k));
        for (int k = 0; k < 5; k++)
            xact(c + 1 + 8 * k, 1'b0, 1'b1, 24'h001000 + 24'(k % 4), 16'(k % 4), k % 4, 16'h1234);
        run(33);
        cl_req = 4'd0;
        run(8);

        // Client 0 alone, continuous reads: one transaction every 8 cycles.
        mem_dout = 16'h5A5A;
        c = cyc;
        set_cl(0, 1'b1, 1'b0, 1'b1, 24'h00ABCD, 16'h0000);
        for (int k = 0; k < 4; k++)
            xact(c + 1 + 8 * k, 1'b0, 1'b1, 24'h00ABCD, 16'h0000, 0, 16'h5A5A);
        run(25);
        cl_req = 4'd0;
        run(8);

        // Reset during WAIT of a read: no ack; a fresh request right after release strobes next cycle.
        c = cyc;
        set_cl(3, 1'b1, 1'b0, 1'b1, 24'hFFFFFE, 16'h0000);
        push_strobe_only(c + 1, 1'b0, 1'b1, 24'hFFFFFE, 16'h0000);
        run(3);
        reset = 1'b1; exp_dout = 16'd0;
        set_cl(3, 1'b0, 1'b0, 1'b1, 24'hFFFFFE, 16'h0000);
        run(1);
        reset = 1'b0;
        c = cyc;
        set_cl(1, 1'b1, 1'b1, 1'b1, 24'h0000AA, 16'h1234);
        xact(c + 1, 1'b1, 1'b1, 24'h0000AA, 16'h1234, 1, 16'h0000);
        run(1);
        set_cl(1, 1'b0, 1'b1, 1'b1, 24'h0000AA, 16'h1234);
        run(10);

        chk("scoreboard_drained", 96'(sq.size() + aq.size()), 96'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
